// File: rtl/mdu_pipelined.sv
// Multiply/divide unit for the EX stage: owns HI/LO, runs timed MULT/MADD/MSUB/DIV
// operations with configurable latency, and supports abort via flush.
module mdu_pipelined #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             rd_sel,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int W2   = 2 * WIDTH;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;

  // Multiplier: both products taken at 2*WIDTH so the low 2*WIDTH bits are exact.
  logic [W2-1:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u, hilo;
  assign a_sx   = {{WIDTH{src_a[WIDTH-1]}}, src_a};
  assign b_sx   = {{WIDTH{src_b[WIDTH-1]}}, src_b};
  assign a_zx   = {{WIDTH{1'b0}}, src_a};
  assign b_zx   = {{WIDTH{1'b0}}, src_b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;
  assign hilo   = {hi_q, lo_q};

  // Divider: signed divide done on magnitudes. The most-negative / -1 case falls
  // out naturally (quotient magnitude wraps back to the dividend, remainder 0).
  logic             b_zero, a_neg, b_neg;
  logic [WIDTH-1:0] b_div, a_mag, b_mag, b_mag_div;
  logic [WIDTH-1:0] qu, ru, qm, rm, qs, rs;
  assign b_zero    = (src_b == '0);
  assign b_div     = b_zero ? WIDTH'(1) : src_b;
  assign qu        = src_a / b_div;
  assign ru        = src_a % b_div;
  assign a_neg     = src_a[WIDTH-1];
  assign b_neg     = src_b[WIDTH-1];
  assign a_mag     = a_neg ? -src_a : src_a;
  assign b_mag     = b_neg ? -src_b : src_b;
  assign b_mag_div = b_zero ? WIDTH'(1) : b_mag;
  assign qm        = a_mag / b_mag_div;
  assign rm        = a_mag % b_mag_div;
  assign qs        = (a_neg ^ b_neg) ? -qm : qm;
  assign rs        = a_neg ? -rm : rm;

  logic          accept, timed, is_div;
  logic [W2-1:0] timed_res;

  always_comb begin
    timed     = 1'b0;
    is_div    = 1'b0;
    timed_res = hilo;
    case (ctrl)
      OP_MULT:  begin timed = 1'b1; timed_res = prod_s;        end
      OP_MULTU: begin timed = 1'b1; timed_res = prod_u;        end
      OP_MADD:  begin timed = 1'b1; timed_res = hilo + prod_s; end
      OP_MADDU: begin timed = 1'b1; timed_res = hilo + prod_u; end
      OP_MSUB:  begin timed = 1'b1; timed_res = hilo - prod_s; end
      OP_MSUBU: begin timed = 1'b1; timed_res = hilo - prod_u; end
      OP_DIV: begin
        timed = 1'b1; is_div = 1'b1;
        if (!b_zero) timed_res = {rs, qs};
      end
      OP_DIVU: begin
        timed = 1'b1; is_div = 1'b1;
        if (!b_zero) timed_res = {ru, qu};
      end
      default: ;
    endcase
  end

  assign accept = start && !busy_q && !flush &&
                  (timed || ctrl == OP_MTHI || ctrl == OP_MTLO);

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    if (busy_q && flush) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (busy_q) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        hi_d   = pend_hi_q;
        lo_d   = pend_lo_q;
        busy_d = 1'b0;
      end
    end else if (accept) begin
      if (ctrl == OP_MTHI) hi_d = src_a;
      else if (ctrl == OP_MTLO) lo_d = src_a;
      else begin
        {pend_hi_d, pend_lo_d} = timed_res;
        cnt_d  = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign result = rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_pipelined.sv
// Self-checking bench for mdu_pipelined: directed scenarios plus randomized ops
// against a plain-arithmetic HI/LO model; a second 16-bit instance covers parameters.
module tb_mdu_pipelined;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, flush = 1'b0, rd_sel = 1'b0, busy;
  logic [3:0]  ctrl = 4'd0;
  logic [31:0] src_a = '0, src_b = '0, result, hi, lo;

  logic        p_start = 1'b0, p_flush = 1'b0, p_rd_sel = 1'b0, p_busy;
  logic [3:0]  p_ctrl = 4'd0;
  logic [15:0] p_a = '0, p_b = '0, p_result, p_hi, p_lo;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  always #5 clk = ~clk;

  mdu_pipelined dut (
    .clk(clk), .reset(reset), .start(start), .ctrl(ctrl), .src_a(src_a), .src_b(src_b),
    .flush(flush), .rd_sel(rd_sel), .busy(busy), .result(result), .hi(hi), .lo(lo)
  );

  mdu_pipelined #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut16 (
    .clk(clk), .reset(reset), .start(p_start), .ctrl(p_ctrl), .src_a(p_a), .src_b(p_b),
    .flush(p_flush), .rd_sel(p_rd_sel), .busy(p_busy), .result(p_result), .hi(p_hi), .lo(p_lo)
  );

  // Reference: HI/LO as one 64-bit value, updated with ordinary integer arithmetic.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] hl, ps, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ps = sa * sb;
    pu = {32'h0, a} * {32'h0, b};
    hl = {m_hi, m_lo};
    case (op)
      4'd1:  hl = ps;
      4'd2:  hl = pu;
      4'd3:  if (b != 0) begin q = sa / sb; r = sa - q * sb; hl = {r[31:0], q[31:0]}; end
      4'd4:  if (b != 0) hl = {a % b, a / b};
      4'd5:  hl[63:32] = a;
      4'd6:  hl[31:0] = a;
      4'd7:  hl = hl + ps;
      4'd8:  hl = hl + pu;
      4'd9:  hl = hl - ps;
      4'd10: hl = hl - pu;
      default: ;
    endcase
    {m_hi, m_lo} = hl;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    ctrl = op; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ctrl = 4'd0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    #12;
    checks++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || result !== 32'h0) begin
      failures++; $display("FAIL reset: busy=%b hi=%h lo=%h result=%h want all 0", busy, hi, lo, result);
    end
    checks++; if (p_busy !== 1'b0 || p_hi !== 16'h0 || p_lo !== 16'h0) begin
      failures++; $display("FAIL reset16: busy=%b hi=%h lo=%h want all 0", p_busy, p_hi, p_lo);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mult;
    int c;
    issue(4'd1, 32'hFFFF_FFFD, 32'd7); model(4'd1, 32'hFFFF_FFFD, 32'd7);
    wait_idle(c);
    checks++; if (c != 5) begin failures++; $display("FAIL mult_busy: got %0d cycles want 5", c); end
    rd_sel = 1'b0; #1;
    checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB || result !== 32'hFFFF_FFEB) begin
      failures++; $display("FAIL mult_val: hi=%h lo=%h result=%h want ffffffff ffffffeb ffffffeb", hi, lo, result);
    end
    rd_sel = 1'b1; #1;
    checks++; if (result !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL mult_rdsel_hi: got %h want ffffffff", result);
    end
    rd_sel = 1'b0;
  endtask

  task automatic test_div;
    int c;
    issue(4'd3, 32'd7, 32'hFFFF_FFFE); model(4'd3, 32'd7, 32'hFFFF_FFFE);
    wait_idle(c);
    checks++; if (c != 10) begin failures++; $display("FAIL div_busy: got %0d cycles want 10", c); end
    checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'd1) begin
      failures++; $display("FAIL div_signed: hi=%h lo=%h want 00000001 fffffffd", hi, lo);
    end
    issue(4'd4, 32'd7, 32'hFFFF_FFFE); model(4'd4, 32'd7, 32'hFFFF_FFFE);
    wait_idle(c);
    checks++; if (lo !== 32'd0 || hi !== 32'd7) begin
      failures++; $display("FAIL divu: hi=%h lo=%h want 00000007 00000000", hi, lo);
    end
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF); model(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(c);
    checks++; if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
      failures++; $display("FAIL div_overflow: hi=%h lo=%h want 00000000 80000000", hi, lo);
    end
  endtask

  task automatic test_acc_move;
    int c;
    issue(4'd5, 32'd0, 32'd0); model(4'd5, 32'd0, 32'd0);
    checks++; if (busy !== 1'b0 || hi !== 32'd0) begin
      failures++; $display("FAIL mthi: busy=%b hi=%h want 0 00000000", busy, hi);
    end
    issue(4'd6, 32'hFFFF_FFFF, 32'd0); model(4'd6, 32'hFFFF_FFFF, 32'd0);
    checks++; if (busy !== 1'b0 || lo !== 32'hFFFF_FFFF || result !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL mtlo: busy=%b lo=%h result=%h want 0 ffffffff ffffffff", busy, lo, result);
    end
    issue(4'd8, 32'd1, 32'd1); model(4'd8, 32'd1, 32'd1);
    wait_idle(c);
    checks++; if (c != 5 || hi !== 32'd1 || lo !== 32'd0) begin
      failures++; $display("FAIL maddu: cycles=%0d hi=%h lo=%h want 5 00000001 00000000", c, hi, lo);
    end
    issue(4'd9, 32'd1, 32'd1); model(4'd9, 32'd1, 32'd1);
    wait_idle(c);
    checks++; if (hi !== 32'd0 || lo !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL msub: hi=%h lo=%h want 00000000 ffffffff", hi, lo);
    end
  endtask

  task automatic test_flush;
    int c;
    issue(4'd5, 32'h11, 32'd0); issue(4'd6, 32'h22, 32'd0);
    model(4'd5, 32'h11, 32'd0); model(4'd6, 32'h22, 32'd0);
    issue(4'd3, 32'd5, 32'd0);
    wait_idle(c);
    checks++; if (c != 10 || hi !== 32'h11 || lo !== 32'h22) begin
      failures++; $display("FAIL div_by_zero: cycles=%0d hi=%h lo=%h want 10 00000011 00000022", c, hi, lo);
    end
    issue(4'd1, 32'd3, 32'd4);
    repeat (2) begin @(posedge clk); #1; end
    flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
    checks++; if (busy !== 1'b0 || hi !== 32'h11 || lo !== 32'h22) begin
      failures++; $display("FAIL flush_mid: busy=%b hi=%h lo=%h want 0 00000011 00000022", busy, hi, lo);
    end
    issue(4'd1, 32'd3, 32'd4);
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flush_last_busy: busy=%b want 1", busy); end
    flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
    checks++; if (busy !== 1'b0 || hi !== 32'h11 || lo !== 32'h22) begin
      failures++; $display("FAIL flush_completion: busy=%b hi=%h lo=%h want 0 00000011 00000022", busy, hi, lo);
    end
    flush = 1'b1; issue(4'd5, 32'h99, 32'd0); flush = 1'b0;
    checks++; if (busy !== 1'b0 || hi !== 32'h11) begin
      failures++; $display("FAIL flush_idle_start: busy=%b hi=%h want 0 00000011", busy, hi);
    end
  endtask

  task automatic test_back_to_back;
    int c;
    issue(4'd1, 32'd6, 32'd7); model(4'd1, 32'd6, 32'd7);
    ctrl = 4'd6; src_a = 32'hDEAD; start = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b0; ctrl = 4'd0;
    wait_idle(c);
    checks++; if (c != 3 || hi !== 32'd0 || lo !== 32'd42) begin
      failures++; $display("FAIL start_while_busy: cycles=%0d hi=%h lo=%h want 3 00000000 0000002a", c, hi, lo);
    end
    issue(4'd4, 32'd100, 32'd7); model(4'd4, 32'd100, 32'd7);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL back_to_back_accept: busy=%b want 1", busy); end
    wait_idle(c);
    checks++; if (lo !== 32'd14 || hi !== 32'd2) begin
      failures++; $display("FAIL back_to_back_val: hi=%h lo=%h want 00000002 0000000e", hi, lo);
    end
  endtask

  task automatic test_reset_mid;
    issue(4'd3, 32'd1000, 32'd3);
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++; $display("FAIL reset_mid_div: busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
    m_hi = '0; m_lo = '0;
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    int c;
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(0, 9));
        1: b = -32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      issue(op, a, b); model(op, a, b);
      wait_idle(c);
      checks++; if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
        failures++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: busy=%b hi=%h lo=%h want 0 %h %h",
                 i, op, a, b, busy, hi, lo, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_param;
    int c;
    p_ctrl = 4'd1; p_a = 16'hFFFF; p_b = 16'h0002; p_start = 1'b1;
    @(posedge clk); #1; p_start = 1'b0; p_ctrl = 4'd0;
    c = 0;
    while (p_busy === 1'b1 && c < 50) begin @(posedge clk); #1; c++; end
    checks++; if (c != 1 || p_hi !== 16'hFFFF || p_lo !== 16'hFFFE) begin
      failures++; $display("FAIL w16_mult: cycles=%0d hi=%h lo=%h want 1 ffff fffe", c, p_hi, p_lo);
    end
    p_ctrl = 4'd4; p_a = 16'd100; p_b = 16'd7; p_start = 1'b1;
    @(posedge clk); #1; p_start = 1'b0; p_ctrl = 4'd0;
    c = 0;
    while (p_busy === 1'b1 && c < 50) begin @(posedge clk); #1; c++; end
    p_rd_sel = 1'b1; #1;
    checks++; if (c != 3 || p_lo !== 16'd14 || p_hi !== 16'd2 || p_result !== 16'd2) begin
      failures++; $display("FAIL w16_divu: cycles=%0d hi=%h lo=%h result=%h want 3 0002 000e 0002", c, p_hi, p_lo, p_result);
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_acc_move;
    test_flush;
    test_back_to_back;
    test_reset_mid;
    test_random;
    test_param;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
